// File: rtl/seq_scan_if.sv
// Handshake and result bundle between a frame source and the sequence-scan controller.
interface seq_scan_if #(
  parameter int DW = 16,
  parameter int PL = 3,
  parameter int CW = 5
);
  logic                    start;
  logic [DW-1:0]           frame;
  logic [PL-1:0]           pat;
  logic                    overlap;
  logic                    busy;
  logic                    done;
  logic                    hit;
  logic [$clog2(DW)-1:0]   hit_pos;
  logic [CW-1:0]           match_cnt;

  modport master (
    output start, frame, pat, overlap,
    input  busy, done, hit, hit_pos, match_cnt
  );

  modport slave (
    input  start, frame, pat, overlap,
    output busy, done, hit, hit_pos, match_cnt
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Shifts a latched frame MSB-first through a PL-bit pattern matcher, reporting
// each match position, a saturating match count and a one-cycle done pulse.
module seq_scan_ctrl #(
  parameter int DW = 16,
  parameter int PL = 3,
  parameter int CW = 5
) (
  input logic      ck,
  input logic      r,
  seq_scan_if.slave bus
);
  localparam int KW = $clog2(DW);
  localparam int NW = $clog2(PL + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   sreg;
  logic [PL-1:0]   pat_q;
  logic            ovl_q;
  logic [PL-1:0]   hist;
  logic [NW-1:0]   nv;
  logic [KW-1:0]   k;

  logic            busy_q, done_q, hit_q;
  logic            busy_nx, done_nx, hit_nx;
  logic [KW-1:0]   pos_q;
  logic [CW-1:0]   cnt_q;

  logic [PL-1:0]   hist_nx;
  logic [NW-1:0]   nv_inc;
  logic            match;
  logic            last;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic [NW-1:0] sat_nv(input logic [NW-1:0] v);
    return (v == NW'(PL)) ? v : v + NW'(1);
  endfunction

  // Match evaluation for the bit currently at the head of the shift register
  always_comb begin
    hist_nx = {hist[PL-2:0], sreg[DW-1]};
    nv_inc  = sat_nv(nv);
    match   = (state == SHIFT) && (nv_inc == NW'(PL)) && (hist_nx == pat_q);
    last    = (k == KW'(DW - 1));
  end

  // State register and registered control outputs
  always_ff @(posedge ck) begin
    if (r) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      hit_q  <= hit_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (state_nx == SHIFT);
    done_nx = (state == DONE);
    hit_nx  = match;
  end

  // Frame datapath: latch on accept, shift and count while scanning
  always_ff @(posedge ck) begin
    if (r) begin
      sreg  <= '0;
      pat_q <= '0;
      ovl_q <= 1'b0;
      hist  <= '0;
      nv    <= '0;
      k     <= '0;
      pos_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sreg  <= bus.frame;
            pat_q <= bus.pat;
            ovl_q <= bus.overlap;
            hist  <= '0;
            nv    <= '0;
            k     <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          sreg <= sreg << 1;
          hist <= hist_nx;
          // Non-overlapping mode needs PL fresh bits after every match
          nv   <= (match && !ovl_q) ? '0 : nv_inc;
          if (!last) k <= k + KW'(1);
          if (match) begin
            pos_q <= k;
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.hit_pos   = pos_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: a window-based reference model predicts hit
// positions, counts and cycle timing; monitors compare what the DUTs present.
module tb_seq_scan_ctrl;
  localparam int DW = 16;
  localparam int PL = 3;
  localparam int CW = 5;
  localparam int CW3 = 3;

  typedef struct {
    bit is_done;
    int pos;
    int cnt;
    int cyc;
  } exp_t;

  logic ck;
  logic r;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;
  exp_t sb[$];
  int   q3[$];

  seq_scan_if #(.DW(DW), .PL(PL), .CW(CW))  b0 ();
  seq_scan_if #(.DW(DW), .PL(PL), .CW(CW3)) b1 ();

  assign b1.start   = b0.start;
  assign b1.frame   = b0.frame;
  assign b1.pat     = b0.pat;
  assign b1.overlap = b0.overlap;

  seq_scan_ctrl #(.DW(DW), .PL(PL), .CW(CW))  u_dut  (.ck(ck), .r(r), .bus(b0));
  seq_scan_ctrl #(.DW(DW), .PL(PL), .CW(CW3)) u_dut3 (.ck(ck), .r(r), .bus(b1));

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic fail(input string name, input int act, input int req);
    total++;
    $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference: a match at bit k is the PL-bit window ending at k, provided at
  // least PL bits have arrived since the frame start or the last
  // non-overlapping match.
  task automatic expect_frame(input logic [DW-1:0] f, input logic [PL-1:0] p,
                              input bit ov, input int t);
    int since = 0;
    int n = 0;
    int w;
    int cmax = (1 << CW) - 1;
    int c3max = (1 << CW3) - 1;
    for (int kk = 0; kk < DW; kk++) begin
      since++;
      w = int'((f >> (DW - 1 - kk)) & DW'((1 << PL) - 1));
      if (since >= PL && w == int'(p)) begin
        n++;
        sb.push_back('{1'b0, kk, (n > cmax) ? cmax : n, t + kk + 1});
        if (!ov) since = 0;
      end
    end
    sb.push_back('{1'b1, 0, (n > cmax) ? cmax : n, t + DW + 1});
    q3.push_back((n > c3max) ? c3max : n);
  endtask

  // Called just after an active edge; returns just after edge t+DW+1.
  task automatic run_frame(input logic [DW-1:0] f, input logic [PL-1:0] p,
                           input bit ov, input bit noise);
    int t;
    b0.start   = 1'b1;
    b0.frame   = f;
    b0.pat     = p;
    b0.overlap = ov;
    t = cyc + 1;
    expect_frame(f, p, ov, t);
    for (int i = 0; i < DW + 2; i++) begin
      @(posedge ck); #1;
      if (noise) begin
        b0.start   = 1'($urandom);
        b0.frame   = DW'($urandom);
        b0.pat     = PL'($urandom);
        b0.overlap = 1'($urandom);
      end else begin
        b0.start = 1'b0;
      end
    end
    b0.start = 1'b0;
  endtask

  // Monitor for the main DUT
  initial begin
    exp_t e;
    int   brun = 0;
    bit   prev_busy = 1'b0;
    forever begin
      @(negedge ck);
      if (b0.busy) brun = prev_busy ? brun + 1 : 1;
      prev_busy = b0.busy;
      if (b0.hit) begin
        if (sb.size() == 0 || sb[0].is_done) fail("unexpected_hit", int'(b0.hit_pos), -1);
        else begin
          e = sb.pop_front();
          chk("hit_pos", int'(b0.hit_pos), e.pos);
          chk("hit_cnt", int'(b0.match_cnt), e.cnt);
          chk("hit_cycle", cyc, e.cyc);
        end
      end
      if (b0.done) begin
        if (sb.size() == 0 || !sb[0].is_done) fail("unexpected_done", cyc, -1);
        else begin
          e = sb.pop_front();
          chk("done_cnt", int'(b0.match_cnt), e.cnt);
          chk("done_cycle", cyc, e.cyc);
          chk("done_busy", int'(b0.busy), 0);
          chk("busy_len", brun, DW);
        end
      end
    end
  end

  // Monitor for the narrow-counter DUT
  initial begin
    forever begin
      @(negedge ck);
      if (b1.done) begin
        if (q3.size() == 0) fail("d3_unexpected_done", cyc, -1);
        else chk("d3_sat_cnt", int'(b1.match_cnt), q3.pop_front());
      end
    end
  end

  initial begin
    b0.start   = 1'b0;
    b0.frame   = '0;
    b0.pat     = '0;
    b0.overlap = 1'b0;
    r = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_done", int'(b0.done), 0);
    chk("rst_hit", int'(b0.hit), 0);
    chk("rst_hit_pos", int'(b0.hit_pos), 0);
    chk("rst_cnt", int'(b0.match_cnt), 0);
    chk("rst_cnt3", int'(b1.match_cnt), 0);
    r = 1'b0;
    @(posedge ck); #1;

    run_frame(16'hA800, 3'b101, 1'b1, 1'b0);
    run_frame(16'hA800, 3'b101, 1'b0, 1'b0);
    run_frame(16'hFFFF, 3'b111, 1'b1, 1'b0);
    // Restart attempts during SHIFT and DONE, then back-to-back accept
    run_frame(16'hA800, 3'b101, 1'b1, 1'b1);
    run_frame(16'hFFFF, 3'b111, 1'b0, 1'b1);
    run_frame(16'h0000, 3'b101, 1'b1, 1'b0);
    repeat (3) begin @(posedge ck); #1; end

    // Reset while shifting bit k=5 with start held high
    b0.start = 1'b1; b0.frame = 16'hA800; b0.pat = 3'b101; b0.overlap = 1'b1;
    expect_frame(16'hA800, 3'b101, 1'b1, cyc + 1);
    repeat (6) begin @(posedge ck); #1; end
    r = 1'b1;
    @(posedge ck); #1;
    sb.delete();
    q3.delete();
    chk("abort_busy", int'(b0.busy), 0);
    chk("abort_done", int'(b0.done), 0);
    chk("abort_hit", int'(b0.hit), 0);
    chk("abort_hit_pos", int'(b0.hit_pos), 0);
    chk("abort_cnt", int'(b0.match_cnt), 0);
    r = 1'b0;
    b0.start = 1'b0;
    repeat (2) begin @(posedge ck); #1; end
    run_frame(16'hA800, 3'b101, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_frame(DW'($urandom), PL'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge ck); #1; end
    end

    for (int i = 0; i < 64 && (sb.size() > 0 || q3.size() > 0); i++) @(posedge ck);
    #1;
    if (sb.size() > 0) fail("drain", sb.size(), 0);
    if (q3.size() > 0) fail("drain3", q3.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
